// File: rtl/l2_vc_miss_initiator.sv
// l2_vc_miss_initiator
// Miss controller on the request side of the L2 <-> victim-cache link.
// On an L2 miss it probes the VC, falls back to memory if the VC misses,
// pushes the L2 victim (with its dirty bit) into the VC, then hands the
// fill line back to the L2 datapath.
//
// Handshake semantics, used for both the VC and the memory port:
//   A request (L2_read, L2_write, pmem_read) is a level that is raised
//   when the controller enters the state owning it. It stays high, with
//   its address/data/dirty fields held stable, until the responder
//   answers in the same cycle (VC_ack / foh for the VC, pmem_resp for
//   memory). The answer is consumed on that clock edge. After any
//   VC_ack the controller spends one cycle with every request low,
//   which covers the VC's post-ack break.
//
// All outputs are decoded from registered state only (Moore); nothing
// from the VC or memory inputs reaches an output combinationally.

module l2_vc_miss_initiator #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   // L2 miss side
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              victim_valid,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [LINE_W-1:0] victim_data,
   output logic              miss_busy,
   output logic              fill_valid,
   output logic [LINE_W-1:0] fill_data,
   // victim cache side
   output logic              L2_read,
   output logic              L2_write,
   output logic              L2_dirty_bit,
   output logic [ADDR_W-1:0] vc_addr,
   output logic [LINE_W-1:0] vc_wdata,
   input  logic [LINE_W-1:0] vc_rdata,
   input  logic              VC_ack,
   input  logic              foh,
   // memory side
   output logic              pmem_read,
   output logic [ADDR_W-1:0] pmem_addr,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              L2toPmem_busy,
   // debug view of the controller state
   output logic [2:0]        dbg_state_o
);

   // Low four address bits are the byte offset inside a 16-byte line.
   localparam int OFF_W = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VC_RD  = 3'd1,
      S_BRK1   = 3'd2,
      S_MEM_RD = 3'd3,
      S_VC_WR  = 3'd4,
      S_BRK2   = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
   logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
   logic              victim_valid_q, victim_valid_d;
   logic              victim_dirty_q, victim_dirty_d;
   logic [LINE_W-1:0] victim_data_q, victim_data_d;
   logic [LINE_W-1:0] fill_q, fill_d;

   // Line-aligned copies of the latched addresses.
   logic [ADDR_W-1:0] miss_line_addr;
   logic [ADDR_W-1:0] victim_line_addr;

   assign miss_line_addr   = {miss_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign victim_line_addr = {victim_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // Next-state and capture logic; inputs only matter in the states that own them.
   always_comb begin
      state_d        = state_q;
      miss_addr_d    = miss_addr_q;
      victim_addr_d  = victim_addr_q;
      victim_valid_d = victim_valid_q;
      victim_dirty_d = victim_dirty_q;
      victim_data_d  = victim_data_q;
      fill_d         = fill_q;

      case (state_q)
         S_IDLE: begin
            if (miss_req) begin
               miss_addr_d    = miss_addr;
               victim_addr_d  = victim_addr;
               victim_valid_d = victim_valid;
               victim_dirty_d = victim_dirty;
               victim_data_d  = victim_data;
               state_d        = S_VC_RD;
            end
         end

         S_VC_RD: begin
            // A hit outranks a simultaneous foh.
            if (VC_ack) begin
               fill_d  = vc_rdata;
               state_d = S_BRK1;
            end else if (foh) begin
               state_d = S_MEM_RD;
            end
         end

         S_BRK1: begin
            state_d = victim_valid_q ? S_VC_WR : S_DONE;
         end

         S_MEM_RD: begin
            if (pmem_resp) begin
               fill_d  = pmem_rdata;
               state_d = victim_valid_q ? S_VC_WR : S_DONE;
            end
         end

         S_VC_WR: begin
            // The VC may first drain its own dirty LRU entry; keep waiting.
            if (VC_ack) begin
               state_d = S_BRK2;
            end
         end

         S_BRK2: begin
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore output decode from the registered state and latched fields.
   always_comb begin
      miss_busy     = 1'b0;
      fill_valid    = 1'b0;
      L2_read       = 1'b0;
      L2_write      = 1'b0;
      L2_dirty_bit  = 1'b0;
      vc_addr       = '0;
      vc_wdata      = '0;
      pmem_read     = 1'b0;
      pmem_addr     = '0;
      L2toPmem_busy = 1'b0;

      if (state_q != S_IDLE) begin
         miss_busy = 1'b1;
      end

      case (state_q)
         S_VC_RD: begin
            L2_read = 1'b1;
            vc_addr = miss_line_addr;
         end
         S_MEM_RD: begin
            pmem_read     = 1'b1;
            L2toPmem_busy = 1'b1;
            pmem_addr     = miss_line_addr;
         end
         S_VC_WR: begin
            L2_write     = 1'b1;
            vc_addr      = victim_line_addr;
            vc_wdata     = victim_data_q;
            L2_dirty_bit = victim_dirty_q;
         end
         S_DONE: begin
            fill_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign fill_data   = fill_q;
   assign dbg_state_o = state_q;

   // State and latch registers; reset aborts any transaction in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         miss_addr_q    <= '0;
         victim_addr_q  <= '0;
         victim_valid_q <= 1'b0;
         victim_dirty_q <= 1'b0;
         victim_data_q  <= '0;
         fill_q         <= '0;
      end else begin
         state_q        <= state_d;
         miss_addr_q    <= miss_addr_d;
         victim_addr_q  <= victim_addr_d;
         victim_valid_q <= victim_valid_d;
         victim_dirty_q <= victim_dirty_d;
         victim_data_q  <= victim_data_d;
         fill_q         <= fill_d;
      end
   end

endmodule

// File: tb/tb_l2_vc_miss_initiator.sv
// Bench for l2_vc_miss_initiator: table of miss transactions with
// hand-computed latencies and request counts, a reactive VC/memory
// responder, and hand-written reset-abort and back-to-back sequences.

module tb_l2_vc_miss_initiator;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT I/O ----------------
   logic              miss_req = 1'b0;
   logic [ADDR_W-1:0] miss_addr = '0;
   logic              victim_valid = 1'b0;
   logic              victim_dirty = 1'b0;
   logic [ADDR_W-1:0] victim_addr = '0;
   logic [LINE_W-1:0] victim_data = '0;
   logic              miss_busy, fill_valid;
   logic [LINE_W-1:0] fill_data;
   logic              L2_read, L2_write, L2_dirty_bit;
   logic [ADDR_W-1:0] vc_addr;
   logic [LINE_W-1:0] vc_wdata;
   logic [LINE_W-1:0] vc_rdata = '0;
   logic              VC_ack = 1'b0;
   logic              foh = 1'b0;
   logic              pmem_read;
   logic [ADDR_W-1:0] pmem_addr;
   logic [LINE_W-1:0] pmem_rdata = '0;
   logic              pmem_resp = 1'b0;
   logic              L2toPmem_busy;
   logic [2:0]        dbg_state;

   l2_vc_miss_initiator #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .miss_req(miss_req), .miss_addr(miss_addr),
      .victim_valid(victim_valid), .victim_dirty(victim_dirty),
      .victim_addr(victim_addr), .victim_data(victim_data),
      .miss_busy(miss_busy), .fill_valid(fill_valid), .fill_data(fill_data),
      .L2_read(L2_read), .L2_write(L2_write), .L2_dirty_bit(L2_dirty_bit),
      .vc_addr(vc_addr), .vc_wdata(vc_wdata), .vc_rdata(vc_rdata),
      .VC_ack(VC_ack), .foh(foh),
      .pmem_read(pmem_read), .pmem_addr(pmem_addr),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .L2toPmem_busy(L2toPmem_busy),
      .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;
   logic [LINE_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- responder configuration ----------------
   logic              cfg_hit, cfg_both;
   int                cfg_rs, cfg_lat, cfg_ws;
   logic [LINE_W-1:0] cfg_line;
   int                rd_cnt, pm_cnt, wr_cnt;
   logic              last_ack;

   // Advance to the next negedge, then answer whatever the DUT requests.
   task automatic tick();
      @(negedge clk);
      last_ack   = VC_ack;
      VC_ack     = 1'b0;
      foh        = 1'b0;
      pmem_resp  = 1'b0;
      vc_rdata   = ~cfg_line;
      pmem_rdata = ~cfg_line;
      if (L2_read) begin
         if (rd_cnt == cfg_rs) begin
            if (cfg_hit) begin
               VC_ack   = 1'b1;
               vc_rdata = cfg_line;
               foh      = cfg_both;
            end else begin
               foh = 1'b1;
            end
         end
         rd_cnt++;
      end
      if (pmem_read) begin
         if (pm_cnt == cfg_lat - 1) begin
            pmem_resp  = 1'b1;
            pmem_rdata = cfg_line;
         end
         pm_cnt++;
      end
      if (L2_write) begin
         if (wr_cnt == cfg_ws) VC_ack = 1'b1;
         wr_cnt++;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string             name;
      logic [15:0]       addr;
      logic              vv, vd;
      logic [15:0]       vaddr;
      logic [LINE_W-1:0] vdata;
      logic              hit, both;
      int                rs, lat, ws;
      logic [LINE_W-1:0] line;
      int                exp_fill;   // cycles after the miss_req sample cycle
      int                exp_rd, exp_pm, exp_wr;
   } vec_t;

   vec_t vecs[7];

   task automatic run_txn(input vec_t v);
      int   fill_k;
      int   proto_err;
      logic [15:0] rd_a, wr_a;
      rd_a = {v.addr[15:4], 4'h0};
      wr_a = {v.vaddr[15:4], 4'h0};
      cfg_hit = v.hit; cfg_both = v.both; cfg_rs = v.rs;
      cfg_lat = v.lat; cfg_ws = v.ws; cfg_line = v.line;
      rd_cnt = 0; pm_cnt = 0; wr_cnt = 0;
      proto_err = 0; fill_k = -1;
      exp_q.push_back(v.line);
      miss_req = 1'b1; miss_addr = v.addr;
      victim_valid = v.vv; victim_dirty = v.vd;
      victim_addr = v.vaddr; victim_data = v.vdata;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 1) begin
            // Inputs are ignored outside IDLE; scramble them to prove latching.
            miss_req = 1'b0; miss_addr = ~v.addr;
            victim_valid = ~v.vv; victim_dirty = ~v.vd;
            victim_addr = ~v.vaddr; victim_data = ~v.vdata;
         end
         if (!miss_busy) proto_err++;
         if (L2_read && L2_write) proto_err++;
         if (last_ack && (L2_read || L2_write)) proto_err++;
         if (L2toPmem_busy != pmem_read) proto_err++;
         if (L2_read && vc_addr != rd_a) proto_err++;
         if (L2_write && (vc_addr != wr_a || vc_wdata != v.vdata ||
                          L2_dirty_bit != v.vd)) proto_err++;
         if (pmem_read && pmem_addr != rd_a) proto_err++;
         if (fill_valid) begin
            fill_k = k;
            break;
         end
      end
      if (fill_k < 0) begin
         check({v.name, " timeout"}, 128'd0, 128'd1);
         exp_q.delete();
      end else begin
         check({v.name, " fill_cycle"}, fill_k, v.exp_fill);
         check({v.name, " fill_data"}, fill_data, exp_q.pop_front());
      end
      check({v.name, " rd_cycles"}, rd_cnt, v.exp_rd);
      check({v.name, " pm_cycles"}, pm_cnt, v.exp_pm);
      check({v.name, " wr_cycles"}, wr_cnt, v.exp_wr);
      check({v.name, " proto"}, proto_err, 0);
      tick();
      check({v.name, " idle_after"}, {miss_busy, fill_valid, L2_read, L2_write, pmem_read}, 5'b0);
   endtask

   // ---------------- test ----------------
   initial begin
      int fill_seen;
      int k2;
      logic [LINE_W-1:0] line_a, line_b;

      //            name    addr     vv    vd    vaddr    vdata           hit   both  rs lat ws line            fill rd pm wr
      vecs[0] = '{"hit",    16'h1230, 1'b0, 1'b0, 16'h0000, '0,            1'b1, 1'b0, 0, 0, 0, {16{8'hA5}},    3, 1, 0, 0};
      vecs[1] = '{"mem_dv", 16'h7780, 1'b1, 1'b1, 16'h4560, {16{8'h5A}},   1'b0, 1'b0, 0, 5, 0, {16{8'h3C}},    9, 1, 5, 1};
      vecs[2] = '{"wr_stl", 16'h2000, 1'b1, 1'b0, 16'h9990, {8{16'hC0DE}}, 1'b1, 1'b0, 0, 0, 7, {16{8'h11}},   12, 1, 0, 8};
      vecs[3] = '{"rd_stl", 16'h3450, 1'b0, 1'b0, 16'h0000, '0,            1'b1, 1'b0, 4, 0, 0, {16{8'h77}},    7, 5, 0, 0};
      vecs[4] = '{"both",   16'h5550, 1'b1, 1'b1, 16'h6660, {16{8'hE1}},   1'b1, 1'b1, 0, 0, 0, {16{8'h99}},    5, 1, 0, 1};
      vecs[5] = '{"mem_nv", 16'hA0A0, 1'b0, 1'b0, 16'h0000, '0,            1'b0, 1'b0, 2, 1, 0, {16{8'h42}},    5, 3, 1, 0};
      vecs[6] = '{"unalgn", 16'hBEEF, 1'b1, 1'b0, 16'h123F, {16{8'hD4}},   1'b0, 1'b0, 1, 3, 2, {16{8'h6B}},   10, 2, 3, 3};

      cfg_hit = 1'b0; cfg_both = 1'b0; cfg_rs = 0; cfg_lat = 1; cfg_ws = 0;
      cfg_line = '0; rd_cnt = 0; pm_cnt = 0; wr_cnt = 0; last_ack = 1'b0;

      // Reset state.
      rst = 1'b1;
      repeat (3) tick();
      check("rst_outputs", {miss_busy, fill_valid, L2_read, L2_write, L2_dirty_bit,
                            pmem_read, L2toPmem_busy}, 7'b0);
      check("rst_buses", {fill_data, vc_addr, vc_wdata, pmem_addr}, '0);
      rst = 1'b0;
      tick();
      check("post_rst_idle", {miss_busy, L2_read, pmem_read}, 3'b0);

      // Table-driven transactions.
      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      // Reset in the middle of a memory read.
      cfg_hit = 1'b0; cfg_both = 1'b0; cfg_rs = 0; cfg_lat = 1000; cfg_ws = 0;
      cfg_line = {16{8'hF0}}; rd_cnt = 0; pm_cnt = 0; wr_cnt = 0;
      miss_req = 1'b1; miss_addr = 16'h4440;
      victim_valid = 1'b1; victim_dirty = 1'b1; victim_addr = 16'h8880;
      victim_data = {16{8'h0F}};
      tick();
      miss_req = 1'b0;
      tick();
      check("rstmid_pmem_on", {pmem_read, L2toPmem_busy}, 2'b11);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_reqs_low", {pmem_read, L2toPmem_busy, miss_busy, L2_read, L2_write}, 5'b0);
      check("rstmid_cleared", {fill_data, pmem_addr, vc_addr}, '0);
      fill_seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (fill_valid) fill_seen++;
      end
      check("rstmid_no_fill", fill_seen, 0);

      // Back-to-back misses with miss_req held high.
      line_a = {8{16'hAB01}};
      line_b = {8{16'hCD02}};
      cfg_hit = 1'b1; cfg_both = 1'b0; cfg_rs = 0; cfg_lat = 1; cfg_ws = 0;
      cfg_line = line_a; rd_cnt = 0; pm_cnt = 0; wr_cnt = 0;
      victim_valid = 1'b0; victim_dirty = 1'b0;
      miss_req = 1'b1; miss_addr = 16'h1110;
      fill_seen = 0;
      for (int k = 0; k < 20 && fill_seen == 0; k++) begin
         tick();
         if (fill_valid) fill_seen = 1;
      end
      check("b2b_first_fill", fill_seen, 1);
      check("b2b_first_data", fill_data, line_a);
      // New address is what the IDLE cycle re-samples.
      miss_addr = 16'h2220;
      cfg_line = line_b;
      rd_cnt = 0;
      tick();
      check("b2b_idle_gap", {miss_busy, L2_read}, 2'b00);
      tick();
      check("b2b_second_read", {L2_read, vc_addr}, {1'b1, 16'h2220});
      miss_req = 1'b0;
      fill_seen = 0;
      k2 = 0;
      for (int k = 0; k < 20 && fill_seen == 0; k++) begin
         tick();
         k2++;
         if (fill_valid) fill_seen = 1;
      end
      check("b2b_second_fill", {fill_seen[0], fill_data}, {1'b1, line_b});
      check("b2b_second_lat", k2, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/l2_vc_miss_initiator.md
# l2_vc_miss_initiator

L2-side miss controller that drives the request end of the L2↔victim-cache (VC) interface. On an L2 miss it looks up the VC, falls back to physical memory on a VC miss, pushes the L2 eviction victim into the VC with its dirty bit, then returns the fill line to the L2 datapath. It also asserts `L2toPmem_busy` so the VC's background writebacks never contend with L2's memory reads.

## Interface
- `ADDR_W`, 16: byte address width.
- `LINE_W`, 128: cache line width in bits (16-byte lines; address bits [3:0] are offset).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `miss_req` in 1: L2 miss pulse/level; sampled only in IDLE.
- `miss_addr` in ADDR_W: missing line address.
- `victim_valid` in 1: L2 victim way holds valid data.
- `victim_dirty` in 1: L2 victim line dirty.
- `victim_addr` in ADDR_W: victim line address.
- `victim_data` in LINE_W: victim line data.
- `miss_busy` out 1: controller not in IDLE.
- `fill_valid` out 1: one-cycle pulse; `fill_data` valid.
- `fill_data` out LINE_W: line returned to L2.
- `L2_read` out 1: VC lookup request.
- `L2_write` out 1: VC insert request.
- `L2_dirty_bit` out 1: dirty bit of inserted line.
- `vc_addr` out ADDR_W: VC request address, bits [3:0] forced 0.
- `vc_wdata` out LINE_W: VC insert data.
- `vc_rdata` in LINE_W: VC hit data, valid with `VC_ack` on reads.
- `VC_ack` in 1: VC accepted request (combinational, same cycle).
- `foh` in 1: VC read miss ("fetch other hierarchy"), combinational, same cycle.
- `pmem_read` out 1: memory line read.
- `pmem_addr` out ADDR_W: memory address, bits [3:0] forced 0.
- `pmem_rdata` in LINE_W: memory data, valid with `pmem_resp`.
- `pmem_resp` in 1: memory read complete.
- `L2toPmem_busy` out 1: L2 owns the memory port.

## Operation
- IDLE entered on any cycle `miss_req`=1: latch `miss_addr`, `victim_valid/dirty/addr/data` into internal registers; go VC_RD. Inputs are ignored in all other states.
- States: IDLE, VC_RD, BRK1, MEM_RD, VC_WR, BRK2, DONE.
- VC_RD: `L2_read`=1, `vc_addr`=latched miss addr. `VC_ack` → capture `vc_rdata` into fill register, go BRK1. Else `foh` → MEM_RD. Neither (VC busy on its own writeback) → stay, hold request.
- BRK1: all requests low (VC spends one cycle in its post-ack break). → VC_WR if latched victim valid, else DONE.
- MEM_RD: `pmem_read`=1, `L2toPmem_busy`=1, `pmem_addr`=miss addr. `pmem_resp` → capture `pmem_rdata`; → VC_WR if victim valid, else DONE.
- VC_WR: `L2_write`=1, `vc_addr`=victim addr, `vc_wdata`=victim data, `L2_dirty_bit`=victim dirty. Hold until `VC_ack` (VC may first write back its dirty LRU entry; request stays asserted, values stable throughout). `VC_ack` → BRK2.
- BRK2: all requests low. → DONE.
- DONE: `fill_valid`=1, `fill_data` = captured line. → IDLE.
- `miss_busy`=1 in every state except IDLE.
- `L2_read` and `L2_write` are never high together. `L2_read`/`L2_write` never asserted in the cycle immediately after a `VC_ack`.
- `foh` and `VC_ack` both high in VC_RD: `VC_ack` wins.

## Timing
- All outputs registered-state-decoded (Moore); no combinational path from VC/pmem inputs to outputs.
- Reset: state IDLE; all outputs 0, including `fill_data`, `vc_addr`, `vc_wdata`, `pmem_addr`; internal latches cleared. Reset mid-transaction aborts immediately: next cycle all requests low, no `fill_valid`. A VC writeback already in flight completes on the VC's side.
- Latency from `miss_req` sampled in cycle N, immediate acks:
  - VC hit, no victim: `fill_valid` at N+3.
  - VC hit, victim: `L2_write` at N+3, `fill_valid` at N+5.
  - VC miss, pmem latency L cycles (`pmem_resp` at N+1+L), victim: `L2_write` N+2+L, `fill_valid` N+4+L.
- Each extra cycle of VC/pmem stall adds exactly one cycle.
- Back-to-back: `miss_req` held high through DONE is re-sampled in IDLE the cycle after DONE; minimum one IDLE cycle between misses.

## Test plan
- VC hit, clean victim absent: `miss_addr`=0x1230, `VC_ack`=1 with `vc_rdata`=0xA5.. in VC_RD → `L2_read` high 1 cycle at `vc_addr` 0x1230, `fill_valid` at N+3 with 0xA5.., `L2_write` never high.
- VC miss, dirty victim: `foh`=1, `pmem_resp` after 5 cycles with 0x3C.., victim 0x4560 dirty → `L2toPmem_busy`=`pmem_read`=1 for 5 cycles, then `L2_write` with `vc_addr` 0x4560, `L2_dirty_bit`=1, `fill_data`=0x3C...
- VC write stall: `VC_ack` withheld 7 cycles in VC_WR → `L2_write`, `vc_addr`, `vc_wdata`, `L2_dirty_bit` stable all 7 cycles; BRK2 cycle has both requests low.
- VC read stall: neither `VC_ack` nor `foh` for 4 cycles, then `VC_ack` → `L2_read` held 5 cycles, single capture.
- Reset mid MEM_RD: `rst`=1 two cycles in → next cycle `pmem_read`=`L2toPmem_busy`=`miss_busy`=0, no `fill_valid` ever for that miss.
- Back-to-back misses with `miss_req` held high → second `L2_read` exactly two cycles after first `fill_valid`, using the address present at re-sample.
